// File: rtl/wb_ack_gate_model_pkg.sv
// Shared sizing and entry layout for the write-back ack gate model.
// All lanes use the same defaults; change them here to retune the model.
package wb_ack_gate_model_pkg;

  localparam int LANES    = 3;
  localparam int DEPTH    = 4;
  localparam int TAG_W    = 6;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 255;

  localparam int PTR_W  = $clog2(DEPTH);
  // The wait counter must be able to hold MAX_WAIT+1, the saturation point.
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lane_fifo.sv
// One write-back lane: a DEPTH-entry FIFO that releases its head once per
// cycle while ack is high, plus a sticky starvation flag on the head entry.
module wb_lane_fifo
  import wb_ack_gate_model_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ack,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

  wb_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              empty;
  logic              push;
  logic              pop;

  // Handshake: a request transfers on a clock edge where req_valid and
  // req_ready are both high; req_ready depends only on fullness, so a pop in
  // the same cycle never frees a slot for that cycle's request.
  assign empty     = (count == '0);
  assign req_ready = (count != CNT_FULL);
  assign push      = req_valid && req_ready;
  assign pop       = ack && !empty;

  always_comb begin
    wait_nxt = wait_cnt;
    if (empty || pop) begin
      wait_nxt = '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_nxt = wait_cnt + WAIT_W'(1);
    end
  end

  // Storage carries no reset; stale slots are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{tag: req_tag, data: req_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        wb_tag  <= mem[rd_ptr].tag;
        wb_data <= mem[rd_ptr].data;
      end
      wb_valid <= pop;
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_SAT) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ack_gate_model.sv
// Three independent write-back lanes gated by random ack strobes, used to
// inject write-back latency into a core and catch ack starvation.
module wb_ack_gate_model
  import wb_ack_gate_model_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_is_wb_ack_0,
  input  logic              io_is_wb_ack_1,
  input  logic              io_is_wb_ack_2,
  input  logic              io_req_valid_0,
  input  logic              io_req_valid_1,
  input  logic              io_req_valid_2,
  output logic              io_req_ready_0,
  output logic              io_req_ready_1,
  output logic              io_req_ready_2,
  input  logic [TAG_W-1:0]  io_req_tag_0,
  input  logic [TAG_W-1:0]  io_req_tag_1,
  input  logic [TAG_W-1:0]  io_req_tag_2,
  input  logic [DATA_W-1:0] io_req_data_0,
  input  logic [DATA_W-1:0] io_req_data_1,
  input  logic [DATA_W-1:0] io_req_data_2,
  output logic              io_wb_valid_0,
  output logic              io_wb_valid_1,
  output logic              io_wb_valid_2,
  output logic [TAG_W-1:0]  io_wb_tag_0,
  output logic [TAG_W-1:0]  io_wb_tag_1,
  output logic [TAG_W-1:0]  io_wb_tag_2,
  output logic [DATA_W-1:0] io_wb_data_0,
  output logic [DATA_W-1:0] io_wb_data_1,
  output logic [DATA_W-1:0] io_wb_data_2,
  output logic              io_err_0,
  output logic              io_err_1,
  output logic              io_err_2
);

  logic [LANES-1:0]  ack;
  logic [LANES-1:0]  req_valid;
  logic [LANES-1:0]  req_ready;
  logic [TAG_W-1:0]  req_tag  [LANES];
  logic [DATA_W-1:0] req_data [LANES];
  logic [LANES-1:0]  wb_valid;
  logic [TAG_W-1:0]  wb_tag   [LANES];
  logic [DATA_W-1:0] wb_data  [LANES];
  logic [LANES-1:0]  err;

  assign ack       = {io_is_wb_ack_2, io_is_wb_ack_1, io_is_wb_ack_0};
  assign req_valid = {io_req_valid_2, io_req_valid_1, io_req_valid_0};
  assign req_tag   = '{io_req_tag_0, io_req_tag_1, io_req_tag_2};
  assign req_data  = '{io_req_data_0, io_req_data_1, io_req_data_2};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    wb_lane_fifo u_lane (
      .clock     (clock),
      .reset     (reset),
      .ack       (ack[l]),
      .req_valid (req_valid[l]),
      .req_ready (req_ready[l]),
      .req_tag   (req_tag[l]),
      .req_data  (req_data[l]),
      .wb_valid  (wb_valid[l]),
      .wb_tag    (wb_tag[l]),
      .wb_data   (wb_data[l]),
      .err       (err[l])
    );
  end

  assign {io_req_ready_2, io_req_ready_1, io_req_ready_0} = req_ready;
  assign {io_wb_valid_2, io_wb_valid_1, io_wb_valid_0}    = wb_valid;
  assign {io_err_2, io_err_1, io_err_0}                   = err;
  assign io_wb_tag_0  = wb_tag[0];
  assign io_wb_tag_1  = wb_tag[1];
  assign io_wb_tag_2  = wb_tag[2];
  assign io_wb_data_0 = wb_data[0];
  assign io_wb_data_1 = wb_data[1];
  assign io_wb_data_2 = wb_data[2];

endmodule

// File: tb/tb_wb_ack_gate_model.sv
// Bench for wb_ack_gate_model: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference of each lane.
module tb_wb_ack_gate_model;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 255;
  localparam int N_PUSH   = 10000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [2:0]  ack;
  logic [2:0]  valid;
  logic [5:0]  req_tag  [3];
  logic [63:0] req_data [3];
  logic [2:0]  ready;
  logic [2:0]  wb_valid;
  logic [5:0]  wb_tag   [3];
  logic [63:0] wb_data  [3];
  logic [2:0]  err;

  wb_ack_gate_model dut (
    .clock          (clock),
    .reset          (reset),
    .io_is_wb_ack_0 (ack[0]),
    .io_is_wb_ack_1 (ack[1]),
    .io_is_wb_ack_2 (ack[2]),
    .io_req_valid_0 (valid[0]),
    .io_req_valid_1 (valid[1]),
    .io_req_valid_2 (valid[2]),
    .io_req_ready_0 (ready[0]),
    .io_req_ready_1 (ready[1]),
    .io_req_ready_2 (ready[2]),
    .io_req_tag_0   (req_tag[0]),
    .io_req_tag_1   (req_tag[1]),
    .io_req_tag_2   (req_tag[2]),
    .io_req_data_0  (req_data[0]),
    .io_req_data_1  (req_data[1]),
    .io_req_data_2  (req_data[2]),
    .io_wb_valid_0  (wb_valid[0]),
    .io_wb_valid_1  (wb_valid[1]),
    .io_wb_valid_2  (wb_valid[2]),
    .io_wb_tag_0    (wb_tag[0]),
    .io_wb_tag_1    (wb_tag[1]),
    .io_wb_tag_2    (wb_tag[2]),
    .io_wb_data_0   (wb_data[0]),
    .io_wb_data_1   (wb_data[1]),
    .io_wb_data_2   (wb_data[2]),
    .io_err_0       (err[0]),
    .io_err_1       (err[1]),
    .io_err_2       (err[2])
  );

  // ---------------- scoreboard / reference ----------------
  int checks   = 0;
  int failures = 0;

  logic [69:0] exp_q [3][$];   // {tag, data} in acceptance order
  logic        m_valid [3];
  logic [5:0]  m_tag   [3];
  logic [63:0] m_data  [3];
  logic        m_err   [3];
  int          m_mark  [3];    // edge at which the current head started waiting
  int          edge_n = 0;
  int          pushes  [3];
  int          tag_ctr [3];
  int          pulses = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h (edge %0d)", name, obs, exp, edge_n);
    end
  endtask

  // Advance one clock: predict the edge from the rules, then compare.
  task automatic step();
    int sz;
    bit pop, push;
    logic [69:0] e;
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("ready%0d", l), ready[l], exp_q[l].size() < DEPTH);
    end
    for (int l = 0; l < 3; l++) begin
      if (reset) begin
        exp_q[l].delete();
        m_valid[l] = 1'b0;
        m_tag[l]   = '0;
        m_data[l]  = '0;
        m_err[l]   = 1'b0;
        m_mark[l]  = edge_n + 1;
      end else begin
        sz   = exp_q[l].size();
        pop  = ack[l] && sz > 0;
        push = valid[l] && sz < DEPTH;
        m_valid[l] = pop;
        if (pop) begin
          e = exp_q[l].pop_front();
          m_tag[l]  = e[69:64];
          m_data[l] = e[63:0];
        end
        if (sz == 0 || pop) m_mark[l] = edge_n + 1;
        else if (edge_n + 1 - m_mark[l] > MAX_WAIT) m_err[l] = 1'b1;
        if (push) begin
          exp_q[l].push_back({req_tag[l], req_data[l]});
          pushes[l]++;
          tag_ctr[l]++;
        end
      end
    end
    @(posedge clock);
    #1;
    edge_n++;
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("wb_valid%0d", l), wb_valid[l], m_valid[l]);
      chk($sformatf("wb_tag%0d", l), wb_tag[l], m_tag[l]);
      chk($sformatf("wb_data%0d", l), wb_data[l], m_data[l]);
      chk($sformatf("err%0d", l), err[l], m_err[l]);
      pulses += int'(wb_valid[l]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ack   = '0;
    valid = '0;
    for (int l = 0; l < 3; l++) begin
      req_tag[l]  = '0;
      req_data[l] = '0;
    end
  endtask

  task automatic push_one(input int l, input logic [5:0] t, input logic [63:0] d);
    valid[l]    = 1'b1;
    req_tag[l]  = t;
    req_data[l] = d;
    step();
    valid[l] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit done;
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", ready, 3'b111);
    chk("rst_wb_valid", wb_valid, 3'b000);
    chk("rst_err", err, 3'b000);

    // Two-cycle minimum latency, single-cycle pulse.
    ack[0] = 1'b1;
    push_one(0, 6'd5, 64'hA5);
    chk("lat1_valid", wb_valid[0], 1'b0);
    step();
    chk("lat2_valid", wb_valid[0], 1'b1);
    chk("lat2_tag", wb_tag[0], 6'd5);
    chk("lat2_data", wb_data[0], 64'hA5);
    step();
    chk("lat3_valid", wb_valid[0], 1'b0);
    chk("lat3_tag_hold", wb_tag[0], 6'd5);
    ack[0] = 1'b0;

    // Fill lane 1, refuse a fifth request, then drain in order.
    for (int i = 0; i < 4; i++) push_one(1, 6'(i), 64'(100 + i));
    chk("full_ready", ready[1], 1'b0);
    push_one(1, 6'd9, 64'h99);
    ack[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("order_valid", wb_valid[1], 1'b1);
      chk("order_tag", wb_tag[1], 6'(i));
    end
    step();
    chk("drained_valid", wb_valid[1], 1'b0);
    ack[1] = 1'b0;

    // Full with ack and valid together: one pop, no push.
    for (int i = 0; i < 4; i++) push_one(1, 6'(10 + i), 64'(200 + i));
    ack[1] = 1'b1;
    push_one(1, 6'd20, 64'h20);
    chk("fp_pop_tag", wb_tag[1], 6'd10);
    chk("fp_ready", ready[1], 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("fp_drain_tag", wb_tag[1], 6'(10 + i));
    end
    step();
    chk("fp_no_extra", wb_valid[1], 1'b0);
    ack[1] = 1'b0;

    // Starvation flag on lane 2.
    push_one(2, 6'd33, 64'h33);
    repeat (MAX_WAIT) step();
    chk("err_at_255", err[2], 1'b0);
    step();
    chk("err_at_256", err[2], 1'b1);
    ack[2] = 1'b1;
    step();
    chk("starved_pop", wb_valid[2], 1'b1);
    step();
    chk("err_sticky", err[2], 1'b1);
    ack[2] = 1'b0;

    // Reset discards queued entries silently.
    for (int i = 0; i < 3; i++) push_one(0, 6'(40 + i), 64'(300 + i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    ack[0] = 1'b1;
    repeat (4) begin
      step();
      chk("post_rst_no_pulse", wb_valid[0], 1'b0);
    end
    chk("post_rst_ready", ready[0], 1'b1);
    chk("post_rst_err", err, 3'b000);
    idle_inputs();

    // Randomized traffic with random acks.
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int l = 0; l < 3; l++) begin
      pushes[l]  = 0;
      tag_ctr[l] = 0;
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      for (int l = 0; l < 3; l++) begin
        ack[l]      = 1'($urandom_range(0, 1));
        valid[l]    = (pushes[l] < N_PUSH) && ($urandom_range(0, 3) != 0);
        req_tag[l]  = 6'(tag_ctr[l]);
        req_data[l] = {$urandom, $urandom};
      end
      step();
      done = (pushes[0] >= N_PUSH) && (pushes[1] >= N_PUSH) && (pushes[2] >= N_PUSH);
    end
    chk("rand_budget", done, 1'b1);
    valid = '0;
    ack   = 3'b111;
    repeat (DEPTH + 2) step();
    chk("rand_pulses", 64'(pulses), 64'(3 * N_PUSH));
    chk("rand_err", err, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
